vscale_htif_pcr_responder: RTL and testbench
============================================

// Module: vscale_htif_pcr_responder
// PURPOSE
//  - Core-side responder for the HTIF PCR request/response interface; the host (testbench or fesvr bridge) is the initiator.
//  - Owns the tohost/fromhost CSRs: accepts host PCR reads/writes and returns one response per request.
//  - Gives the core pipeline's CSR file a side port to read/write both registers. Sits inside vscale_top beside the CSR file.
// PARAMETERS
//  - PCR_W      64       width of PCR data (matches `HTIF_PCR_WIDTH)
//  - ADDR_W     12       width of PCR address (CSR address space)
// PORTS
//  - clk                  in   1       core clock, all logic rising-edge
//  - reset_n              in   1       asynchronous, active-low reset
//  - htif_pcr_req_valid   in   1       host request valid
//  - htif_pcr_req_ready   out  1       responder can accept request
//  - htif_pcr_req_rw      in   1       1 = write (swap), 0 = read
//  - htif_pcr_req_addr    in   ADDR_W  target CSR address
//  - htif_pcr_req_data    in   PCR_W   write data
//  - htif_pcr_resp_valid  out  1       response valid
//  - htif_pcr_resp_ready  in   1       host accepts response
//  - htif_pcr_resp_data   out  PCR_W   old register value (read or swap)
//  - csr_tohost_wen       in   1       core writes tohost this cycle
//  - csr_fromhost_wen     in   1       core writes fromhost this cycle
//  - csr_wdata            in   PCR_W   core write data
//  - tohost               out  PCR_W   current tohost value
//  - fromhost             out  PCR_W   current fromhost value
//  - fromhost_pending     out  1       fromhost nonzero (core wakeup/poll)
// BEHAVIOUR
//  - Reset (async, reset_n=0): tohost=0, fromhost=0, resp_valid=0, resp_data=0, state=IDLE; req_ready=1 one cycle after deassert.
//  - FSM: IDLE (no response held) and RESP (response held). req_ready = (state==IDLE) || htif_pcr_resp_ready.
//  - Request fires on req_valid&&req_ready in cycle N; resp_valid=1 in N+1. Result is captured at the N edge and sampled from pre-edge regs.
//  - Back-to-back: in RESP with resp_ready=1 and a new request, go straight to RESP with new data; throughput 1/cycle.
//  - RESP with resp_ready=0: resp_valid and resp_data held stable; req_ready=0.
//  - RESP with resp_ready=1 and no request: return to IDLE, resp_valid=0.
//  - Address decode: `CSR_ADDR_TO_HOST (0x780) -> tohost, `CSR_ADDR_FROM_HOST (0x781) -> fromhost.
//  - Any other address: resp_data=0, write ignored; still exactly one response.
//  - Read (rw=0): resp_data = register value. Write (rw=1): resp_data = old value, register <= req_data (swap).
//  - Conflict, host write and core write to the same register in one cycle: core write wins. Response still carries the pre-edge value.
//  - Core writes never stall and take effect at the next edge. Outputs tohost/fromhost are direct register outputs.
//  - fromhost_pending = |fromhost (combinational from the register).
//  - Reset during RESP drops the response; the host must reissue.
// CONFIGURATION
//  - Macro VSCALE_HTIF_TOHOST_CLR_ON_READ_EN.
//  - Defined: a host read (rw=0) of tohost returns its value and clears tohost to 0 at the same edge.
//    A core write in that cycle still wins.
//  - Undefined: reads have no side effects; the host clears tohost with an explicit write of 0.
// STRUCTURE
//  - Shared header vscale_htif_constants.vh holds:
//    - `HTIF_PCR_WIDTH
//    - responder state encodings (`HTIF_RSP_IDLE, `HTIF_RSP_BUSY)
//    - `CSR_ADDR_TO_HOST / `CSR_ADDR_FROM_HOST, reused from vscale_csr_addr_map.vh
//  - Single flat module; no sub-module is needed. Decode and swap mux are inline.
// TESTING
//  - Reset, then read 0x780 -> resp_valid at N+1, resp_data=0, req_ready=1 throughout.
//  - Core writes tohost=0x1; host reads 0x780 with resp_ready=1 every cycle -> resp_data=0x1.
//    With CLR_ON_READ_EN, a second read returns 0; without it, the second read returns 0x1.
//  - Host writes 0x781 with data 0x55 -> resp_data=0 (old value).
//    Next cycle fromhost=0x55 and fromhost_pending=1; core writes 0 -> pending=0.
//  - Hold resp_ready=0 for 5 cycles -> resp_valid/resp_data stable, req_ready=0.
//    Release -> a pending request is accepted that cycle and its response appears next cycle.
//  - Same-cycle host write 0xAA and core write 0xBB to tohost -> tohost=0xBB, resp_data = prior value.
//  - Read of 0x123 -> resp_data=0, no register change. Assert reset_n=0 during RESP -> resp_valid=0 immediately.

Source files
------------

// File: rtl/vscale_htif_pcr_responder_pkg.sv
// +--------------------------------------------------------------------+
// | vscale_htif_pcr_responder_pkg                                      |
// | Shared HTIF PCR width, responder state encodings, CSR addresses.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package vscale_htif_pcr_responder_pkg;

    localparam int HTIF_PCR_WIDTH = 64;

    localparam logic [0:0] HTIF_RSP_IDLE = 1'b0;
    localparam logic [0:0] HTIF_RSP_BUSY = 1'b1;

    localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
    localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;

endpackage

`default_nettype wire

// File: rtl/vscale_htif_pcr_responder.sv
// +--------------------------------------------------------------------+
// | vscale_htif_pcr_responder                                          |
// | Owns tohost/fromhost; answers host PCR read/swap requests.         |
// | Option macro: VSCALE_HTIF_TOHOST_CLR_ON_READ_EN    Rev 1.0         |
// +--------------------------------------------------------------------+
`default_nettype none

module vscale_htif_pcr_responder
    import vscale_htif_pcr_responder_pkg::*;
#(
    parameter int PCR_W  = HTIF_PCR_WIDTH,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              htif_pcr_req_valid,
    output logic              htif_pcr_req_ready,
    input  logic              htif_pcr_req_rw,
    input  logic [ADDR_W-1:0] htif_pcr_req_addr,
    input  logic [PCR_W-1:0]  htif_pcr_req_data,
    output logic              htif_pcr_resp_valid,
    input  logic              htif_pcr_resp_ready,
    output logic [PCR_W-1:0]  htif_pcr_resp_data,
    input  logic              csr_tohost_wen,
    input  logic              csr_fromhost_wen,
    input  logic [PCR_W-1:0]  csr_wdata,
    output logic [PCR_W-1:0]  tohost,
    output logic [PCR_W-1:0]  fromhost,
    output logic              fromhost_pending
);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [PCR_W-1:0] tohost_q;
    logic [PCR_W-1:0] tohost_d;
    logic [PCR_W-1:0] fromhost_q;
    logic [PCR_W-1:0] fromhost_d;
    logic [PCR_W-1:0] resp_data_q;
    logic [PCR_W-1:0] resp_data_d;

    logic             w_fire;
    logic             w_sel_to;
    logic             w_sel_from;
    logic [PCR_W-1:0] w_old;

    assign w_fire     = htif_pcr_req_valid && htif_pcr_req_ready;
    assign w_sel_to   = (htif_pcr_req_addr == ADDR_W'(CSR_ADDR_TO_HOST));
    assign w_sel_from = (htif_pcr_req_addr == ADDR_W'(CSR_ADDR_FROM_HOST));

    // Response always carries the pre-edge value, regardless of who writes.
    assign w_old = w_sel_to   ? tohost_q   :
                   w_sel_from ? fromhost_q : '0;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HTIF_RSP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            HTIF_RSP_IDLE: begin
                if (w_fire) state_d = HTIF_RSP_BUSY;
            end
            HTIF_RSP_BUSY: begin
                if (w_fire)                   state_d = HTIF_RSP_BUSY;
                else if (htif_pcr_resp_ready) state_d = HTIF_RSP_IDLE;
            end
            default: state_d = HTIF_RSP_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        htif_pcr_resp_valid = (state_q == HTIF_RSP_BUSY);
        htif_pcr_req_ready  = (state_q == HTIF_RSP_IDLE) || htif_pcr_resp_ready;
    end

    // Host swap first, core write last so the core wins any conflict.
    always_comb begin
        tohost_d    = tohost_q;
        fromhost_d  = fromhost_q;
        resp_data_d = resp_data_q;
        if (w_fire) begin
            resp_data_d = w_old;
            if (htif_pcr_req_rw) begin
                if (w_sel_to)   tohost_d   = htif_pcr_req_data;
                if (w_sel_from) fromhost_d = htif_pcr_req_data;
            end
`ifdef VSCALE_HTIF_TOHOST_CLR_ON_READ_EN
            else if (w_sel_to) begin
                tohost_d = '0;
            end
`endif
        end
        if (csr_tohost_wen)   tohost_d   = csr_wdata;
        if (csr_fromhost_wen) fromhost_d = csr_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tohost_q    <= '0;
            fromhost_q  <= '0;
            resp_data_q <= '0;
        end else begin
            tohost_q    <= tohost_d;
            fromhost_q  <= fromhost_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign htif_pcr_resp_data = resp_data_q;
    assign tohost             = tohost_q;
    assign fromhost           = fromhost_q;
    assign fromhost_pending   = |fromhost_q;

endmodule

`default_nettype wire

// File: tb/tb_vscale_htif_pcr_responder.sv
// +--------------------------------------------------------------------+
// | tb_vscale_htif_pcr_responder                                       |
// | Directed vector table plus stall and reset sequences.   Rev 1.0    |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vscale_htif_pcr_responder;

`ifdef VSCALE_HTIF_TOHOST_CLR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_rw;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_data;
    logic        tohost_wen;
    logic        fromhost_wen;
    logic [63:0] wdata;
    logic [63:0] tohost;
    logic [63:0] fromhost;
    logic        pending;

    int checks = 0;
    int errors = 0;

    vscale_htif_pcr_responder dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .csr_tohost_wen      (tohost_wen),
        .csr_fromhost_wen    (fromhost_wen),
        .csr_wdata           (wdata),
        .tohost              (tohost),
        .fromhost            (fromhost),
        .fromhost_pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic        rw;
        logic [11:0] addr;
        logic [63:0] data;
        logic        rr;
        logic        tw;
        logic        fw;
        logic [63:0] wd;
        logic        e_rdy;
        logic        e_rv;
        logic [63:0] e_rd;
        logic [63:0] e_to;
        logic [63:0] e_fr;
        logic        e_p;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(logic vld, logic rw, logic [11:0] addr, logic [63:0] data,
                                logic rr, logic tw, logic fw, logic [63:0] wd,
                                logic e_rdy, logic e_rv, logic [63:0] e_rd,
                                logic [63:0] e_to, logic [63:0] e_fr, logic e_p);
        vec_t v;
        v.vld = vld; v.rw = rw; v.addr = addr; v.data = data; v.rr = rr;
        v.tw = tw; v.fw = fw; v.wd = wd; v.e_rdy = e_rdy; v.e_rv = e_rv;
        v.e_rd = e_rd; v.e_to = e_to; v.e_fr = e_fr; v.e_p = e_p;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(logic vld, logic rw, logic [11:0] addr, logic [63:0] data,
                         logic rr, logic tw, logic fw, logic [63:0] wd);
        req_valid = vld; req_rw = rw; req_addr = addr; req_data = data;
        resp_ready = rr; tohost_wen = tw; fromhost_wen = fw; wdata = wd;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [63:0] t1;
    logic [63:0] tbb;
    logic [63:0] rbb;

    initial begin
        t1  = CLR ? 64'h0 : 64'h1;
        tbb = CLR ? 64'h0 : 64'hBB;
        rbb = CLR ? 64'h0 : 64'hBB;

        //         vld rw addr     data      rr tw fw wd       rdy rv rd        to        fr       p
        vt[0]  = mk(1, 0, 12'h780, 64'h0,    1, 0, 0, 64'h0,   1,  1, 64'h0,    64'h0,    64'h0,   0);
        vt[1]  = mk(0, 0, 12'h000, 64'h0,    1, 1, 0, 64'h1,   1,  0, 64'h0,    64'h1,    64'h0,   0);
        vt[2]  = mk(1, 0, 12'h780, 64'h0,    1, 0, 0, 64'h0,   1,  1, 64'h1,    t1,       64'h0,   0);
        vt[3]  = mk(1, 0, 12'h780, 64'h0,    1, 0, 0, 64'h0,   1,  1, t1,       t1,       64'h0,   0);
        vt[4]  = mk(1, 1, 12'h781, 64'h55,   1, 0, 0, 64'h0,   1,  1, 64'h0,    t1,       64'h55,  1);
        vt[5]  = mk(0, 0, 12'h000, 64'h0,    1, 0, 1, 64'h0,   1,  0, 64'h0,    t1,       64'h0,   0);
        vt[6]  = mk(1, 1, 12'h780, 64'hAA,   1, 1, 0, 64'hBB,  1,  1, t1,       64'hBB,   64'h0,   0);
        vt[7]  = mk(1, 0, 12'h123, 64'h0,    1, 0, 0, 64'h0,   1,  1, 64'h0,    64'hBB,   64'h0,   0);
        vt[8]  = mk(1, 1, 12'h123, 64'hFFFF, 1, 0, 0, 64'h0,   1,  1, 64'h0,    64'hBB,   64'h0,   0);
        vt[9]  = mk(1, 0, 12'h781, 64'h0,    1, 0, 1, 64'h77,  1,  1, 64'h0,    64'hBB,   64'h77,  1);
        vt[10] = mk(1, 1, 12'h781, 64'h0,    1, 0, 0, 64'h0,   1,  1, 64'h77,   64'hBB,   64'h0,   0);
        vt[11] = mk(1, 0, 12'h780, 64'h0,    1, 0, 0, 64'h0,   1,  1, 64'hBB,   tbb,      64'h0,   0);
        vt[12] = mk(1, 0, 12'h780, 64'h0,    1, 1, 0, 64'h33,  1,  1, rbb,      64'h33,   64'h0,   0);
        vt[13] = mk(0, 0, 12'h000, 64'h0,    1, 0, 1, 64'h99,  1,  0, rbb,      64'h33,   64'h99,  1);

        drive(0, 0, 12'h0, 64'h0, 1, 0, 0, 64'h0);
        reset_n = 1'b0;
        #12;
        chk("reset_resp_valid", {63'h0, resp_valid}, 64'h0);
        chk("reset_resp_data", resp_data, 64'h0);
        chk("reset_tohost", tohost, 64'h0);
        chk("reset_fromhost", fromhost, 64'h0);
        chk("reset_pending", {63'h0, pending}, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].vld, vt[i].rw, vt[i].addr, vt[i].data,
                  vt[i].rr, vt[i].tw, vt[i].fw, vt[i].wd);
            #1;
            chk($sformatf("v%0d_req_ready", i), {63'h0, req_ready}, {63'h0, vt[i].e_rdy});
            cycle();
            chk($sformatf("v%0d_resp_valid", i), {63'h0, resp_valid}, {63'h0, vt[i].e_rv});
            chk($sformatf("v%0d_resp_data", i), resp_data, vt[i].e_rd);
            chk($sformatf("v%0d_tohost", i), tohost, vt[i].e_to);
            chk($sformatf("v%0d_fromhost", i), fromhost, vt[i].e_fr);
            chk($sformatf("v%0d_pending", i), {63'h0, pending}, {63'h0, vt[i].e_p});
        end

        // Backpressure: response held, next request stalled until resp_ready.
        drive(1, 0, 12'h781, 64'h0, 0, 0, 0, 64'h0);
        #1;
        chk("stall_first_ready", {63'h0, req_ready}, 64'h1);
        cycle();
        chk("stall_first_rv", {63'h0, resp_valid}, 64'h1);
        chk("stall_first_rd", resp_data, 64'h99);
        drive(1, 1, 12'h780, 64'h44, 0, 0, 0, 64'h0);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("stall%0d_ready", k), {63'h0, req_ready}, 64'h0);
            cycle();
            chk($sformatf("stall%0d_rv", k), {63'h0, resp_valid}, 64'h1);
            chk($sformatf("stall%0d_rd", k), resp_data, 64'h99);
            chk($sformatf("stall%0d_tohost", k), tohost, 64'h33);
        end
        resp_ready = 1'b1;
        #1;
        chk("release_ready", {63'h0, req_ready}, 64'h1);
        cycle();
        chk("release_rv", {63'h0, resp_valid}, 64'h1);
        chk("release_rd", resp_data, 64'h33);
        chk("release_tohost", tohost, 64'h44);
        drive(0, 0, 12'h0, 64'h0, 1, 0, 0, 64'h0);
        cycle();
        chk("drain_rv", {63'h0, resp_valid}, 64'h0);

        // Reset while a response is held.
        drive(1, 0, 12'h781, 64'h0, 0, 0, 0, 64'h0);
        cycle();
        chk("prereset_rv", {63'h0, resp_valid}, 64'h1);
        chk("prereset_rd", resp_data, 64'h99);
        drive(0, 0, 12'h0, 64'h0, 0, 0, 0, 64'h0);
        reset_n = 1'b0;
        #1;
        chk("midreset_rv", {63'h0, resp_valid}, 64'h0);
        chk("midreset_rd", resp_data, 64'h0);
        chk("midreset_tohost", tohost, 64'h0);
        chk("midreset_fromhost", fromhost, 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        chk("postreset_ready", {63'h0, req_ready}, 64'h1);
        chk("postreset_rv", {63'h0, resp_valid}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
